hls_macc_result_accum: RTL

- Downstream sequencer and accumulator for the motion MACC core.
- Drives the core's ap_start and watches ap_done.
- On each completed call, captures the core's three 32-bit results (out1..out3 with their ap_vld strobes) and adds them into signed frame accumulators.
- After FRAME_LEN calls, presents the three frame sums on a valid/ready output and starts the next frame.

---
 rtl/hls_macc_result_accum.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hls_macc_result_accum.sv
// rtl/hls_macc_result_accum.sv - sequencer and signed frame accumulator for the motion MACC core
module hls_macc_result_accum #(
  parameter  int FRAME_LEN = 4,
  parameter  int ACC_W     = 40,
  parameter  int TIMEOUT   = 64,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1),
  localparam int WD_W      = $clog2(TIMEOUT + 1)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             enable,
  input  logic             err_clear,
  output logic             core_start,
  input  logic             core_done,
  input  logic [31:0]      core_out1,
  input  logic [31:0]      core_out2,
  input  logic [31:0]      core_out3,
  input  logic             core_out1_vld,
  input  logic             core_out2_vld,
  input  logic             core_out3_vld,
  output logic [ACC_W-1:0] res_sum1,
  output logic [ACC_W-1:0] res_sum2,
  output logic [ACC_W-1:0] res_sum3,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_timeout,
  output logic             err_missing_vld,
  output logic [2:0]       acc_ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EMIT, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q [3];
  logic [ACC_W-1:0] acc_d [3];
  logic [ACC_W-1:0] addend [3];
  logic [ACC_W-1:0] sum [3];
  logic [31:0]      lane_out [3];
  logic [2:0]       lane_vld;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             tmo_q, tmo_d;
  logic             mis_q, mis_d;
  logic [2:0]       ovf_q, ovf_d;

  // Lane views, sign-extended addends and wrapping sums
  always_comb begin
    lane_out[0] = core_out1;
    lane_out[1] = core_out2;
    lane_out[2] = core_out3;
    lane_vld    = {core_out3_vld, core_out2_vld, core_out1_vld};
    for (int n = 0; n < 3; n++) begin
      addend[n] = {{(ACC_W-32){lane_out[n][31]}}, lane_out[n]};
      sum[n]    = acc_q[n] + addend[n];
    end
  end

  // Next-state logic for the sequencer, accumulators, watchdog and sticky flags
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    tmo_d   = tmo_q;
    mis_d   = mis_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (enable) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (core_done) begin
          for (int n = 0; n < 3; n++) begin
            if (lane_vld[n]) begin
              acc_d[n] = sum[n];
              // Signed overflow: operands agree in sign, result does not
              if ((acc_q[n][ACC_W-1] == addend[n][ACC_W-1]) &&
                  (sum[n][ACC_W-1] != acc_q[n][ACC_W-1]))
                ovf_d[n] = 1'b1;
            end else begin
              mis_d = 1'b1;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          wd_d  = '0;
          if ((cnt_q + CNT_W'(1)) == CNT_W'(FRAME_LEN)) state_d = S_EMIT;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            tmo_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          for (int n = 0; n < 3; n++) acc_d[n] = '0;
          cnt_d   = '0;
          ovf_d   = '0;
          mis_d   = 1'b0;
          state_d = enable ? S_ISSUE : S_IDLE;
        end
      end
      S_ERR: begin
        if (err_clear) begin
          for (int n = 0; n < 3; n++) acc_d[n] = '0;
          cnt_d   = '0;
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      for (int n = 0; n < 3; n++) acc_q[n] <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      tmo_q   <= 1'b0;
      mis_q   <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int n = 0; n < 3; n++) acc_q[n] <= acc_d[n];
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
      mis_q   <= mis_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decoded from registered state; sums hold still in EMIT since accumulators do
  always_comb begin
    core_start      = (state_q == S_ISSUE);
    res_valid       = (state_q == S_EMIT);
    busy            = (state_q != S_IDLE);
    res_sum1        = acc_q[0];
    res_sum2        = acc_q[1];
    res_sum3        = acc_q[2];
    frame_cnt       = cnt_q;
    err_timeout     = tmo_q;
    err_missing_vld = mis_q;
    acc_ovf         = ovf_q;
  end

endmodule
